// File: rtl/out_frame_sched.sv
// Output-side frame scheduler: round-robin grant among NCH requesters, then
// streams the granted frame's words from the shared FIFO into the serializer.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame active; arbitration and length check happen here
// READ  | granted frame in progress; one word in flight at a time
// DONE  | final word loaded; acknowledge requester for one cycle
module out_frame_sched #(
   parameter int NCH       = 8,
   parameter int LEN_W     = 4,
   parameter int MAX_WORDS = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk_out,
   input  logic                 rst,
   input  logic [NCH-1:0]       req,
   input  logic [NCH*LEN_W-1:0] req_len,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic                 ser_ready,
   output logic                 ser_load,
   output logic                 ser_last,
   output logic [NCH-1:0]       ser_ch,
   output logic [NCH-1:0]       grant_ack,
   output logic                 busy,
   output logic                 len_err,
   output logic                 stall_err
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [LEN_W:0] MAXW = (LEN_W+1)'(MAX_WORDS);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

   state_t state, state_nx;

   logic [IW-1:0]    last, ch, win, idx;
   logic             win_vld, len_ok, abort;
   logic [NCH-1:0]   req_m, ack_q;
   logic [LEN_W-1:0] len, issued, loaded, win_len;
   logic             inflight;
   logic [TW-1:0]    tmo;
   logic             len_err_q, stall_err_q;

   function automatic logic [NCH-1:0] onehot(input logic [IW-1:0] i);
      onehot    = '0;
      onehot[i] = 1'b1;
   endfunction

   // A requester may still hold req during its ack cycle; mask it so it is not re-granted.
   assign req_m = req & ~ack_q;

   // Descending scan so the nearest set bit after 'last' is the final assignment.
   always_comb begin
      win_vld = 1'b0;
      win     = last;
      idx     = last;
      for (int k = NCH; k >= 1; k--) begin
         idx = IW'((32'(last) + k) % NCH);
         if (req_m[idx]) begin
            win_vld = 1'b1;
            win     = idx;
         end
      end
   end

   assign win_len = req_len[win*LEN_W +: LEN_W];
   assign len_ok  = (win_len != '0) && ({1'b0, win_len} <= MAXW);

   assign abort      = (state == READ) && (tmo == TMO_LAST) && !inflight;
   assign fifo_rd_en = (state == READ) && ser_ready && !fifo_empty && !inflight
                       && (issued < len) && !abort;
   assign ser_load   = inflight;
   assign ser_last   = inflight && (loaded == len - LEN_W'(1));

   assign busy      = (state != IDLE);
   assign ser_ch    = (state != IDLE) ? onehot(ch) : '0;
   assign grant_ack = ack_q | ((state == DONE) ? onehot(ch) : '0);
   assign len_err   = len_err_q;
   assign stall_err = stall_err_q;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (win_vld && len_ok) state_nx = READ;
         READ: begin
            if (ser_last)   state_nx = DONE;
            else if (abort) state_nx = IDLE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_out or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last        <= IW'(NCH - 1);
         ch          <= '0;
         len         <= '0;
         issued      <= '0;
         loaded      <= '0;
         inflight    <= 1'b0;
         tmo         <= '0;
         ack_q       <= '0;
         len_err_q   <= 1'b0;
         stall_err_q <= 1'b0;
      end else begin
         state       <= state_nx;
         ack_q       <= '0;
         len_err_q   <= 1'b0;
         stall_err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  ch       <= win;
                  len      <= win_len;
                  issued   <= '0;
                  loaded   <= '0;
                  inflight <= 1'b0;
                  tmo      <= '0;
                  if (!len_ok) begin
                     len_err_q <= 1'b1;
                     ack_q     <= onehot(win);
                     last      <= win;
                  end
               end
            end
            READ: begin
               if (fifo_rd_en) begin
                  inflight <= 1'b1;
                  issued   <= issued + LEN_W'(1);
               end
               if (inflight) begin
                  inflight <= 1'b0;
                  loaded   <= loaded + LEN_W'(1);
                  tmo      <= '0;
               end else begin
                  tmo <= tmo + TW'(1);
               end
               // Abandon the frame; words already read are not rolled back.
               if (abort) begin
                  stall_err_q <= 1'b1;
                  ack_q       <= onehot(ch);
                  last        <= ch;
               end
            end
            DONE:    last <= ch;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_out_frame_sched.sv
// Directed bench for out_frame_sched: arbitration order, frame sequencing,
// length errors, backpressure, timeout abort and mid-frame reset.
module tb_out_frame_sched;

   logic        clk_out = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  req = '0;
   logic [31:0] req_len = '0;
   logic        fifo_empty = 1'b0;
   logic        fifo_rd_en;
   logic        ser_ready = 1'b1;
   logic        ser_load;
   logic        ser_last;
   logic [7:0]  ser_ch;
   logic [7:0]  grant_ack;
   logic        busy;
   logic        len_err;
   logic        stall_err;

   int checks = 0;
   int failures = 0;

   int cyc = 0, rd_cnt = 0, ld_cnt = 0, last_cnt = 0, ld_at_last = 0;
   int ld_gap2 = 0, prev_ld = -100, busy_cnt = 0, ch_bad = 0;
   int len_err_cnt = 0, stall_cnt = 0;
   logic [7:0] exp_ch = '0;

   out_frame_sched dut (
      .clk_out    (clk_out),
      .rst        (rst),
      .req        (req),
      .req_len    (req_len),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .ser_ready  (ser_ready),
      .ser_load   (ser_load),
      .ser_last   (ser_last),
      .ser_ch     (ser_ch),
      .grant_ack  (grant_ack),
      .busy       (busy),
      .len_err    (len_err),
      .stall_err  (stall_err)
   );

   always #5 clk_out = ~clk_out;

   always @(negedge clk_out) begin
      if (!rst) begin
         cyc = cyc + 1;
         if (fifo_rd_en) rd_cnt = rd_cnt + 1;
         if (ser_load) begin
            ld_cnt = ld_cnt + 1;
            if (cyc - prev_ld == 2) ld_gap2 = ld_gap2 + 1;
            prev_ld = cyc;
         end
         if (ser_last) begin
            last_cnt   = last_cnt + 1;
            ld_at_last = ld_cnt;
         end
         if (busy) busy_cnt = busy_cnt + 1;
         if (busy && ser_ch != exp_ch) ch_bad = ch_bad + 1;
         if (len_err) len_err_cnt = len_err_cnt + 1;
         if (stall_err) stall_cnt = stall_cnt + 1;
      end
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_grant(input string tag, input int max_cyc, output logic [7:0] g);
      g = '0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk_out);
         if (grant_ack != 8'h00) begin
            g = grant_ack;
            return;
         end
      end
      checks++;
      failures++;
      $error("FAIL %s observed=no_grant expected=grant_within_%0d", tag, max_cyc);
   endtask

   initial begin
      logic [7:0] g;
      int s_rd, s_ld, s_last, s_gap, s_busy, s_bad, s_le, s_st, n;

      // ---- reset state ----
      #1 rst = 1'b1;
      #1;
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_ser_load", ser_load, 0);
      chk("rst_ser_last", ser_last, 0);
      chk("rst_ser_ch", ser_ch, 0);
      chk("rst_grant", grant_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_len_err", len_err, 0);
      chk("rst_stall_err", stall_err, 0);
      repeat (2) @(negedge clk_out);

      // ---- round robin, req 8'h11 held: ch0, ch4, ch0, ch4 ----
      req_len = 32'h1111_1111;
      rst = 1'b0;
      req = 8'h11;
      wait_grant("rr11_0", 20, g); chk("rr11_g0", g, 8'h01);
      wait_grant("rr11_1", 20, g); chk("rr11_g1", g, 8'h10);
      wait_grant("rr11_2", 20, g); chk("rr11_g2", g, 8'h01);
      wait_grant("rr11_3", 20, g); chk("rr11_g3", g, 8'h10);
      req = 8'h00;
      repeat (2) @(negedge clk_out);

      // ---- single frame, cycle exact ----
      exp_ch = 8'h01;
      req = 8'h01;
      @(negedge clk_out);
      chk("one_rd_en", fifo_rd_en, 1);
      chk("one_busy", busy, 1);
      chk("one_ser_ch", ser_ch, 8'h01);
      @(negedge clk_out);
      chk("one_load", ser_load, 1);
      chk("one_last", ser_last, 1);
      chk("one_rd_en_gap", fifo_rd_en, 0);
      @(negedge clk_out);
      chk("one_grant", grant_ack, 8'h01);
      chk("one_load_off", ser_load, 0);
      req = 8'h00;
      @(negedge clk_out);
      chk("one_idle_busy", busy, 0);
      chk("one_idle_ch", ser_ch, 0);
      chk("one_idle_grant", grant_ack, 0);

      // ---- round robin, req 8'hFF: ch1..ch7 then ch0 ----
      req = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         wait_grant("rrff", 20, g);
         chk("rrff_order", g, 8'(1) << ((k + 1) % 8));
         req = req & ~g;
      end
      repeat (2) @(negedge clk_out);

      // ---- length errors on ch2: 0 then 9 ----
      s_rd = rd_cnt; s_busy = busy_cnt; s_le = len_err_cnt;
      req_len = 32'h0000_0000;
      req = 8'h04;
      @(negedge clk_out);
      chk("len0_err", len_err, 1);
      chk("len0_grant", grant_ack, 8'h04);
      chk("len0_busy", busy, 0);
      req = 8'h00;
      @(negedge clk_out);
      chk("len0_err_pulse", len_err, 0);
      req_len = 32'h0000_0900;
      req = 8'h04;
      @(negedge clk_out);
      chk("len9_err", len_err, 1);
      chk("len9_grant", grant_ack, 8'h04);
      req = 8'h00;
      repeat (2) @(negedge clk_out);
      chk("lenerr_rd_cnt", rd_cnt - s_rd, 0);
      chk("lenerr_busy_cnt", busy_cnt - s_busy, 0);
      chk("lenerr_pulses", len_err_cnt - s_le, 2);

      // ---- max frame on ch1, 8 words ----
      s_rd = rd_cnt; s_ld = ld_cnt; s_last = last_cnt; s_gap = ld_gap2; s_bad = ch_bad;
      exp_ch = 8'h02;
      req_len = 32'h0000_0080;
      req = 8'h02;
      wait_grant("max_wait", 60, g);
      chk("max_grant", g, 8'h02);
      req = 8'h00;
      repeat (2) @(negedge clk_out);
      chk("max_rd_cnt", rd_cnt - s_rd, 8);
      chk("max_ld_cnt", ld_cnt - s_ld, 8);
      chk("max_last_cnt", last_cnt - s_last, 1);
      chk("max_last_idx", ld_at_last - s_ld, 8);
      chk("max_spacing2", ld_gap2 - s_gap, 7);
      chk("max_ch_stable", ch_bad - s_bad, 0);
      chk("max_idle", busy, 0);

      // ---- backpressure on ch3: 4 words, ser_ready low 10 cycles after word 2 ----
      s_ld = ld_cnt; s_st = stall_cnt; s_bad = ch_bad;
      exp_ch = 8'h08;
      req_len = 32'h0000_4000;
      req = 8'h08;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_out);
         if (ser_load) n++;
         if (n == 2) break;
      end
      chk("bp_two_loads", n, 2);
      ser_ready = 1'b0;
      s_rd = rd_cnt;
      repeat (10) @(negedge clk_out);
      chk("bp_paused_rd", rd_cnt - s_rd, 0);
      chk("bp_still_busy", busy, 1);
      ser_ready = 1'b1;
      wait_grant("bp_wait", 30, g);
      chk("bp_grant", g, 8'h08);
      req = 8'h00;
      repeat (2) @(negedge clk_out);
      chk("bp_ld_cnt", ld_cnt - s_ld, 4);
      chk("bp_no_stall", stall_cnt - s_st, 0);
      chk("bp_ch_stable", ch_bad - s_bad, 0);

      // ---- timeout on ch5: FIFO stays empty ----
      s_rd = rd_cnt; s_busy = busy_cnt; s_st = stall_cnt;
      exp_ch = 8'h20;
      req_len = 32'h0020_0000;
      fifo_empty = 1'b1;
      req = 8'h20;
      n = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk_out);
         if (stall_err) begin
            n = i;
            break;
         end
      end
      chk("stall_latency", n, 65);
      chk("stall_grant", grant_ack, 8'h20);
      chk("stall_busy", busy, 0);
      req = 8'h00;
      fifo_empty = 1'b0;
      repeat (2) @(negedge clk_out);
      chk("stall_busy_cycles", busy_cnt - s_busy, 64);
      chk("stall_rd_cnt", rd_cnt - s_rd, 0);
      chk("stall_pulses", stall_cnt - s_st, 1);

      // ---- reset after word 3 of 8 on ch6 ----
      s_st = stall_cnt; s_le = len_err_cnt;
      exp_ch = 8'h40;
      req_len = 32'h0800_0000;
      req = 8'h40;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_out);
         if (ser_load) n++;
         if (n == 3) break;
      end
      chk("mid_three_loads", n, 3);
      rst = 1'b1;
      #1;
      chk("mid_rst_load", ser_load, 0);
      chk("mid_rst_rd_en", fifo_rd_en, 0);
      chk("mid_rst_ch", ser_ch, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_grant", grant_ack, 0);
      @(negedge clk_out);
      exp_ch = 8'h01;
      req_len = 32'h1000_0001;
      req = 8'h81;
      @(negedge clk_out);
      rst = 1'b0;
      @(negedge clk_out);
      chk("post_rst_rd_en", fifo_rd_en, 1);
      chk("post_rst_ch", ser_ch, 8'h01);
      wait_grant("post_rst_a", 20, g);
      chk("post_rst_first", g, 8'h01);
      req = req & ~g;
      exp_ch = 8'h80;
      wait_grant("post_rst_b", 20, g);
      chk("post_rst_second", g, 8'h80);
      req = 8'h00;
      repeat (2) @(negedge clk_out);
      chk("mid_no_stall", stall_cnt - s_st, 0);
      chk("mid_no_len_err", len_err_cnt - s_le, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
